ps2_mouse_packet_decoder: RTL and testbench
===========================================

Name: ps2_mouse_packet_decoder

Overview:
- Sits directly downstream of the PS/2 mouse receive path. Consumes the byte stream that arrives once the mouse stream-mode init sequence (reset 0xFF, enable 0xF4) has completed.
- Assembles 3-byte PS/2 mouse packets and resynchronises on framing errors.
- Sign-extends the movement fields and maintains a clamped screen-space cursor position plus button state for the 640x480 VGA overlay.

Parameters:
- SCREEN_W, 640, cursor X range is [0, SCREEN_W-1]
- SCREEN_H, 480, cursor Y range is [0, SCREEN_H-1]
- X_INIT, 320, cursor X after reset
- Y_INIT, 240, cursor Y after reset
- TIMEOUT_CYCLES, 100000, maximum gap between bytes of one packet (only used with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  high once mouse init is complete; low holds the decoder idle
- rx_done_tick  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- pkt_valid  out  1  one-cycle pulse: a new packet was applied
- btn_left, btn_right, btn_middle  out  1 each  button state from the last valid packet
- dx  out  9  signed X movement of the last packet
- dy  out  9  signed Y movement of the last packet
- cursor_x  out  10  clamped cursor X
- cursor_y  out  10  clamped cursor Y
- sync_err  out  1  one-cycle pulse: a byte was dropped for framing reasons

Behaviour:
- Reset: state BYTE0, cursor_x=X_INIT, cursor_y=Y_INIT, buttons=0, dx=dy=0, pkt_valid=0, sync_err=0, internal byte registers=0.
- FSM states: BYTE0, BYTE1, BYTE2, UPDATE.
- BYTE0, on tick:
  - rx_data[3]==1: latch as status byte, go to BYTE1.
  - rx_data[3]==0: drop the byte, pulse sync_err the next cycle, stay in BYTE0.
- BYTE1, on tick: latch the X byte, go to BYTE2.
- BYTE2, on tick: latch the Y byte, go to UPDATE.
- UPDATE (exactly 1 cycle):
  - dx = {status[4], xbyte}, dy = {status[5], ybyte}.
  - If status[6] (X overflow) is set, dx=0. If status[7] (Y overflow) is set, dy=0.
  - Buttons: left=status[0], right=status[1], middle=status[2].
  - Next X = cursor_x + dx. Next Y = cursor_y - dy (PS/2 +Y is up; screen Y grows down).
  - Both sums use 12-bit signed intermediates. Clamp below 0 to 0, and above SCREEN_x-1 to SCREEN_x-1.
  - Return to BYTE0.
- Output timing: all outputs are registered. dx, dy, buttons, cursor_x, cursor_y and pkt_valid all update on the edge that leaves UPDATE.
  - pkt_valid is high for exactly one cycle.
  - Latency: pkt_valid is high 2 cycles after the cycle in which the byte-2 tick was sampled.
- Tick arriving during UPDATE: processed with BYTE0 rules in the same cycle (next state BYTE1, or a sync_err pulse). It is never lost.
- enable low:
  - Ticks are ignored and the state is forced to BYTE0.
  - A partial packet is discarded with no sync_err.
  - Cursor and buttons hold.
  - If enable falls during UPDATE, the update still completes.
- Reset mid-packet: returns to the reset state immediately; partial bytes are discarded.
- Boundary example: at cursor_x=639, dx=+255 yields cursor_x=639. At cursor_x=0, dx=-256 yields cursor_x=0.

Optional Feature:
- Macro: PS2_MOUSE_TIMEOUT_EN.
- Defined: a counter restarts on each accepted byte while in BYTE1 or BYTE2. If TIMEOUT_CYCLES cycles elapse with no tick, the FSM returns to BYTE0, discards the partial packet, and pulses sync_err for one cycle. The counter is held at 0 in BYTE0, in UPDATE, and while enable is low.
- Not defined: no counter exists, and a partial packet waits indefinitely for its remaining bytes.

Test Plan:
- Reset, then enable=1 and bytes 0x08, 0x05, 0x03 -> pkt_valid once, 2 cycles after the third tick; dx=+5, dy=+3, cursor=(325,237), no buttons.
- Bytes 0x39 (Xsign, Ysign, left), 0xFB, 0xFE -> dx=-5, dy=-2, btn_left=1, cursor moves from (320,240) to (315,242).
- Cursor at (635,2), packet 0x08, 0x7F, 0x7F -> cursor=(639,0) clamped.
- Stray byte 0x00 in BYTE0, then 0x09, 0x01, 0x00 -> one sync_err pulse; the packet then decodes with btn_left=1 and dx=+1.
- Packet 0x48 (X overflow), 0x10, 0x04 -> dx=0, dy=+4, cursor_x unchanged.
- With PS2_MOUSE_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 0x08, 0x01, wait 60 cycles, then 0x08, 0x02, 0x00 -> one sync_err at the timeout, then a single pkt_valid with dx=+2.

Source files
------------

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte-stream inputs and decoded mouse-state outputs of ps2_mouse_packet_decoder.
// master drives the received bytes; slave is the decoder.
interface ps2_mouse_packet_decoder_if;
   logic              enable;
   logic              rx_done_tick;
   logic [7:0]        rx_data;
   logic              pkt_valid;
   logic              btn_left;
   logic              btn_right;
   logic              btn_middle;
   logic signed [8:0] dx;
   logic signed [8:0] dy;
   logic [9:0]        cursor_x;
   logic [9:0]        cursor_y;
   logic              sync_err;

   modport master (
      output enable, rx_done_tick, rx_data,
      input  pkt_valid, btn_left, btn_right, btn_middle, dx, dy,
             cursor_x, cursor_y, sync_err
   );

   modport slave (
      input  enable, rx_done_tick, rx_data,
      output pkt_valid, btn_left, btn_right, btn_middle, dx, dy,
             cursor_x, cursor_y, sync_err
   );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets into button state and a clamped cursor position.
// Define PS2_MOUSE_TIMEOUT_EN to abandon partial packets after TIMEOUT_CYCLES idle cycles.
module ps2_mouse_packet_decoder #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int X_INIT   = 320,
   parameter int Y_INIT   = 240
`ifdef PS2_MOUSE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 100000
`endif
) (
   input logic                       clk,
   input logic                       rst,
   ps2_mouse_packet_decoder_if.slave bus
);

   typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, UPDATE} state_t;

   // Status byte minus bit 3, which is only a framing marker.
   typedef struct packed {
      logic y_ovf;
      logic x_ovf;
      logic y_sign;
      logic x_sign;
      logic middle;
      logic right;
      logic left;
   } status_t;

   localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

   state_t             state;
   status_t            status;
   logic [7:0]         xbyte;
   logic [7:0]         ybyte;
   logic signed [8:0]  dx_next;
   logic signed [8:0]  dy_next;
   logic signed [11:0] sum_x;
   logic signed [11:0] sum_y;
   logic [9:0]         x_next;
   logic [9:0]         y_next;
   logic               tick;
   logic               timeout_hit;

   assign tick = bus.enable && bus.rx_done_tick;

   // NOTE: every always_comb output gets a value on every path so no latch is inferred.
   always_comb begin
      dx_next = status.x_ovf ? 9'sd0 : $signed({status.x_sign, xbyte});
      dy_next = status.y_ovf ? 9'sd0 : $signed({status.y_sign, ybyte});
      sum_x   = $signed({2'b00, bus.cursor_x}) + $signed({{3{dx_next[8]}}, dx_next});
      sum_y   = $signed({2'b00, bus.cursor_y}) - $signed({{3{dy_next[8]}}, dy_next});

      if (sum_x < 12'sd0)      x_next = '0;
      else if (sum_x > X_MAX)  x_next = X_MAX[9:0];
      else                     x_next = sum_x[9:0];

      if (sum_y < 12'sd0)      y_next = '0;
      else if (sum_y > Y_MAX)  y_next = Y_MAX[9:0];
      else                     y_next = sum_y[9:0];
   end

`ifdef PS2_MOUSE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;

   // Counts idle cycles only while a packet is partially assembled.
   always_ff @(posedge clk) begin
      if (rst || !bus.enable || tick || state == BYTE0 || state == UPDATE)
         timer <= '0;
      else
         timer <= timer + TW'(1);
   end

   assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= BYTE0;
         status         <= '0;
         xbyte          <= '0;
         ybyte          <= '0;
         bus.pkt_valid  <= 1'b0;
         bus.sync_err   <= 1'b0;
         bus.btn_left   <= 1'b0;
         bus.btn_right  <= 1'b0;
         bus.btn_middle <= 1'b0;
         bus.dx         <= '0;
         bus.dy         <= '0;
         bus.cursor_x   <= 10'(X_INIT);
         bus.cursor_y   <= 10'(Y_INIT);
      end else begin
         bus.pkt_valid <= 1'b0;
         bus.sync_err  <= 1'b0;

         // The update completes even if enable drops during this cycle.
         if (state == UPDATE) begin
            bus.pkt_valid  <= 1'b1;
            bus.dx         <= dx_next;
            bus.dy         <= dy_next;
            bus.btn_left   <= status.left;
            bus.btn_right  <= status.right;
            bus.btn_middle <= status.middle;
            bus.cursor_x   <= x_next;
            bus.cursor_y   <= y_next;
         end

         if (!bus.enable) begin
            state <= BYTE0;
         end else begin
            case (state)
               BYTE0, UPDATE: begin
                  state <= BYTE0;
                  if (tick) begin
                     if (bus.rx_data[3]) begin
                        status <= '{y_ovf:  bus.rx_data[7], x_ovf: bus.rx_data[6],
                                    y_sign: bus.rx_data[5], x_sign: bus.rx_data[4],
                                    middle: bus.rx_data[2], right: bus.rx_data[1],
                                    left:   bus.rx_data[0]};
                        state  <= BYTE1;
                     end else begin
                        bus.sync_err <= 1'b1;
                     end
                  end
               end
               BYTE1: begin
                  if (tick) begin
                     xbyte <= bus.rx_data;
                     state <= BYTE2;
                  end else if (timeout_hit) begin
                     state        <= BYTE0;
                     bus.sync_err <= 1'b1;
                  end
               end
               BYTE2: begin
                  if (tick) begin
                     ybyte <= bus.rx_data;
                     state <= UPDATE;
                  end else if (timeout_hit) begin
                     state        <= BYTE0;
                     bus.sync_err <= 1'b1;
                  end
               end
               default: state <= BYTE0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Self-checking bench for ps2_mouse_packet_decoder: packet table, corner sequences,
// and random byte streams compared against a queue-based packet model.
module tb_ps2_mouse_packet_decoder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ps2_mouse_packet_decoder_if bus ();

`ifdef PS2_MOUSE_TIMEOUT_EN
   ps2_mouse_packet_decoder #(.TIMEOUT_CYCLES(50)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
   ps2_mouse_packet_decoder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      bit         rst_first;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      int         dx;
      int         dy;
      int         btns;   // {middle, right, left}
      int         cx;
      int         cy;
   } vec_t;

   typedef struct {
      bit pv;
      bit err;
      int dx;
      int dy;
      int btns;
      int cx;
      int cy;
   } exp_t;

   vec_t       vecs [12];
   exp_t       exp_at [0:2047];
   logic [7:0] q [$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         rc = 0;
   int         pv_seen = 0;
   int         err_seen = 0;
   int         m_cx, m_cy, d_cx, d_cy;
   int         r;
   logic [7:0] b;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rc++;
      if (bus.pkt_valid) pv_seen++;
      if (bus.sync_err)  err_seen++;
   endtask

   task automatic send(input logic [7:0] val);
      bus.rx_data      = val;
      bus.rx_done_tick = 1'b1;
      step();
      bus.rx_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic int btns_now();
      return int'({bus.btn_middle, bus.btn_right, bus.btn_left});
   endfunction

   task automatic check_cursor(input string name, input int x, input int y);
      check({name, " cursor_x"}, int'(bus.cursor_x), x);
      check({name, " cursor_y"}, int'(bus.cursor_y), y);
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      bus.enable       = 1'b0;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      step();
      step();
      check("reset pkt_valid", int'(bus.pkt_valid), 0);
      check("reset sync_err", int'(bus.sync_err), 0);
      check("reset dx", int'($signed(bus.dx)), 0);
      check("reset dy", int'($signed(bus.dy)), 0);
      check("reset buttons", btns_now(), 0);
      check_cursor("reset", 320, 240);
      rst      = 1'b0;
      pv_seen  = 0;
      err_seen = 0;
   endtask

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference: a packet is three bytes starting with one that has bit 3 set.
   task automatic model_byte(input logic [7:0] val);
      int mdx, mdy;
      if (q.size() == 0 && !val[3]) begin
         exp_at[rc + 1].err = 1'b1;
      end else begin
         q.push_back(val);
         if (q.size() == 3) begin
            mdx  = q[0][6] ? 0 : int'(q[1]) - (q[0][4] ? 256 : 0);
            mdy  = q[0][7] ? 0 : int'(q[2]) - (q[0][5] ? 256 : 0);
            m_cx = clamp(m_cx + mdx, 0, 639);
            m_cy = clamp(m_cy - mdy, 0, 479);
            exp_at[rc + 2].pv   = 1'b1;
            exp_at[rc + 2].dx   = mdx;
            exp_at[rc + 2].dy   = mdy;
            exp_at[rc + 2].btns = int'(q[0][2:0]);
            exp_at[rc + 2].cx   = m_cx;
            exp_at[rc + 2].cy   = m_cy;
            q.delete();
         end
      end
   endtask

   task automatic check_cycle();
      check($sformatf("rnd pkt_valid c%0d", rc), int'(bus.pkt_valid), int'(exp_at[rc].pv));
      check($sformatf("rnd sync_err c%0d", rc), int'(bus.sync_err), int'(exp_at[rc].err));
      if (exp_at[rc].pv) begin
         d_cx = exp_at[rc].cx;
         d_cy = exp_at[rc].cy;
         check($sformatf("rnd dx c%0d", rc), int'($signed(bus.dx)), exp_at[rc].dx);
         check($sformatf("rnd dy c%0d", rc), int'($signed(bus.dy)), exp_at[rc].dy);
         check($sformatf("rnd buttons c%0d", rc), btns_now(), exp_at[rc].btns);
      end
      check_cursor($sformatf("rnd c%0d", rc), d_cx, d_cy);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 8'h08, 8'h05, 8'h03,    5,    3, 0, 325, 237};
      vecs[1]  = '{1'b1, 8'h39, 8'hFB, 8'hFE,   -5,   -2, 1, 315, 242};
      vecs[2]  = '{1'b1, 8'h08, 8'hFF, 8'hEE,  255,  238, 0, 575,   2};
      vecs[3]  = '{1'b0, 8'h08, 8'h3C, 8'h00,   60,    0, 0, 635,   2};
      vecs[4]  = '{1'b0, 8'h08, 8'h7F, 8'h7F,  127,  127, 0, 639,   0};
      vecs[5]  = '{1'b0, 8'h08, 8'hFF, 8'h00,  255,    0, 0, 639,   0};
      vecs[6]  = '{1'b0, 8'h48, 8'h10, 8'h04,    0,    4, 0, 639,   0};
      vecs[7]  = '{1'b1, 8'h18, 8'h00, 8'h00, -256,    0, 0,  64, 240};
      vecs[8]  = '{1'b0, 8'h18, 8'h00, 8'h00, -256,    0, 0,   0, 240};
      vecs[9]  = '{1'b0, 8'h2E, 8'h00, 8'h00,    0, -256, 6,   0, 479};
      vecs[10] = '{1'b0, 8'h88, 8'h02, 8'h50,    2,    0, 0,   2, 479};
      vecs[11] = '{1'b0, 8'hCF, 8'h33, 8'h44,    0,    0, 7,   2, 479};

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].rst_first) begin
            do_reset();
            bus.enable = 1'b1;
         end
         send(vecs[i].b0);
         send(vecs[i].b1);
         send(vecs[i].b2);
         check($sformatf("v%0d pkt_valid early", i), int'(bus.pkt_valid), 0);
         step();
         check($sformatf("v%0d pkt_valid", i), int'(bus.pkt_valid), 1);
         check($sformatf("v%0d dx", i), int'($signed(bus.dx)), vecs[i].dx);
         check($sformatf("v%0d dy", i), int'($signed(bus.dy)), vecs[i].dy);
         check($sformatf("v%0d buttons", i), btns_now(), vecs[i].btns);
         check_cursor($sformatf("v%0d", i), vecs[i].cx, vecs[i].cy);
         step();
         check($sformatf("v%0d pkt_valid width", i), int'(bus.pkt_valid), 0);
      end

      // Stray byte, then a good packet.
      do_reset();
      bus.enable = 1'b1;
      send(8'h00);
      check("stray sync_err pulse", int'(bus.sync_err), 1);
      send(8'h09);
      check("stray sync_err width", int'(bus.sync_err), 0);
      send(8'h01);
      send(8'h00);
      step();
      check("stray pkt_valid", int'(bus.pkt_valid), 1);
      check("stray sync_err count", err_seen, 1);
      check("stray dx", int'($signed(bus.dx)), 1);
      check("stray buttons", btns_now(), 1);
      check_cursor("stray", 321, 240);

      // Byte 0 of the next packet arrives during UPDATE.
      do_reset();
      bus.enable = 1'b1;
      send(8'h08); send(8'h01); send(8'h01);
      send(8'h08); send(8'h02); send(8'h02);
      idle(3);
      check("b2b pkt count", pv_seen, 2);
      check("b2b sync_err count", err_seen, 0);
      check("b2b dx", int'($signed(bus.dx)), 2);
      check_cursor("b2b", 323, 237);

      // enable drop discards a partial packet silently.
      do_reset();
      bus.enable = 1'b1;
      send(8'h08); send(8'h05);
      bus.enable = 1'b0;
      step();
      bus.enable = 1'b1;
      send(8'h08); send(8'h01); send(8'h02);
      idle(3);
      check("endrop pkt count", pv_seen, 1);
      check("endrop sync_err count", err_seen, 0);
      check_cursor("endrop", 321, 238);

      // enable falls during UPDATE; ticks while disabled are ignored.
      do_reset();
      bus.enable = 1'b1;
      send(8'h08); send(8'h04); send(8'h04);
      bus.enable       = 1'b0;
      bus.rx_data      = 8'h08;
      bus.rx_done_tick = 1'b1;
      idle(4);
      bus.rx_done_tick = 1'b0;
      check("enupd pkt count", pv_seen, 1);
      check("enupd sync_err count", err_seen, 0);
      check_cursor("enupd", 324, 236);

      // Reset in the middle of a packet.
      do_reset();
      bus.enable = 1'b1;
      send(8'h08); send(8'h05); send(8'h03);
      idle(2);
      send(8'h08); send(8'h05);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_cursor("midrst", 320, 240);
      check("midrst pkt_valid", int'(bus.pkt_valid), 0);
      send(8'h03);
      check("midrst byte0 sync_err", int'(bus.sync_err), 1);

      // Long gap inside a packet.
      do_reset();
      bus.enable = 1'b1;
      send(8'h08); send(8'h01);
      idle(60);
      send(8'h08); send(8'h02); send(8'h00);
      idle(3);
      check("gap pkt count", pv_seen, 1);
`ifdef PS2_MOUSE_TIMEOUT_EN
      check("gap sync_err count", err_seen, 1);
      check("gap dx", int'($signed(bus.dx)), 2);
      check_cursor("gap", 322, 240);
`else
      check("gap sync_err count", err_seen, 2);
      check("gap dx", int'($signed(bus.dx)), 1);
      check("gap dy", int'($signed(bus.dy)), 8);
      check_cursor("gap", 321, 232);
`endif

      // Random byte stream against the packet model.
      do_reset();
      rc = 0;
      for (int i = 0; i < 2048; i++) exp_at[i] = '{default: 0};
      q.delete();
      m_cx = 320; m_cy = 240; d_cx = 320; d_cy = 240;
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 99));
         b = 8'($urandom);
         if (r < 4) begin
            bus.enable       = 1'b0;
            bus.rx_done_tick = r[0];
            bus.rx_data      = b;
            q.delete();
         end else begin
            bus.enable = 1'b1;
            if (r < 60) begin
               if (q.size() == 0) b[3] = ($urandom_range(0, 9) != 0);
               bus.rx_data      = b;
               bus.rx_done_tick = 1'b1;
               model_byte(b);
            end else begin
               bus.rx_done_tick = 1'b0;
            end
         end
         step();
         bus.rx_done_tick = 1'b0;
         check_cycle();
      end
      bus.enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
